// File: rtl/compress_arbiter.sv
// Round-robin arbiter feeding N byte streams into one compressor, with burst limit and stall abort.
// Optional build macro COMPRESS_ARB_PRIO_EN: requester 0 always wins arbitration when it is valid.
module compress_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 8,
  parameter int STALL_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_vld,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_rdy,
  input  logic              dc_rdy,
  output logic [7:0]        dc_din,
  output logic              dc_den,
  output logic              dc_hold,
  output logic [2:0]        grant_id,
  output logic              busy,
  output logic              err_timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, STALL} state_e;

  state_e      state_q, state_d;
  logic [2:0]  gnt_q, gnt_d, rr_q, rr_d, rr_nxt, pick;
  logic [7:0]  beat_q, beat_d, stall_q, stall_d, din_q, din_d;
  logic        den_q, den_d, err_q, err_d;
  logic        xfer;

  // Requester vectors widened to 8 entries so a 3-bit owner index is always in range.
  logic [7:0]      vld_ext, last_ext, rdy_ext;
  logic [7:0][7:0] data_ext;

  always_comb begin
    vld_ext  = 8'(req_vld);
    last_ext = 8'(req_last);
    data_ext = '0;
    for (int i = 0; i < NREQ; i++) data_ext[i] = req_data[8*i +: 8];
  end

  // Scan offsets high to low so the nearest valid requester above rr_q is assigned last.
  always_comb begin
    pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      int idx;
      idx = int'(rr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (vld_ext[idx[2:0]]) pick = idx[2:0];
    end
`ifdef COMPRESS_ARB_PRIO_EN
    if (req_vld[0]) pick = '0;
`endif
  end

  assign rr_nxt = (gnt_q == 3'(NREQ - 1)) ? 3'd0 : gnt_q + 3'd1;
  assign xfer   = (state_q != IDLE) && vld_ext[gnt_q] && dc_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      stall_q <= '0;
      din_q   <= '0;
      den_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      stall_q <= stall_d;
      din_q   <= din_d;
      den_q   <= den_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    stall_d = stall_q;
    din_d   = din_q;
    den_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_vld && dc_rdy) begin
          state_d = GRANT;
          gnt_d   = pick;
          beat_d  = '0;
          stall_d = '0;
        end
      end
      GRANT, STALL: begin
        if (xfer) begin
          din_d   = data_ext[gnt_q];
          den_d   = 1'b1;
          beat_d  = beat_q + 8'd1;
          stall_d = '0;
          state_d = GRANT;
          if (last_ext[gnt_q] || (beat_q + 8'd1 == 8'(MAX_BURST))) begin
            state_d = IDLE;
            rr_d    = rr_nxt;
            beat_d  = '0;
          end
        end else if (dc_rdy) begin
          // A missing beat only counts as a stall while the compressor could have taken it.
          if (state_q == GRANT) begin
            state_d = STALL;
            stall_d = '0;
          end else if (stall_q + 8'd1 == 8'(STALL_MAX)) begin
            state_d = IDLE;
            err_d   = 1'b1;
            rr_d    = rr_nxt;
            beat_d  = '0;
            stall_d = '0;
          end else begin
            stall_d = stall_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdy_ext = '0;
    if (state_q != IDLE) rdy_ext[gnt_q] = dc_rdy;
    req_rdy     = rdy_ext[NREQ-1:0];
    dc_din      = din_q;
    dc_den      = den_q;
    dc_hold     = (state_q == STALL);
    grant_id    = gnt_q;
    busy        = (state_q != IDLE);
    err_timeout = err_q;
  end

endmodule

// File: tb/tb_compress_arbiter.sv
// Randomized + directed bench for compress_arbiter against a transaction-level reference model.
module tb_compress_arbiter;
  localparam int NREQ = 4;
  localparam int MAXB = 8;
  localparam int SMAX = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_vld = '0, req_last = '0, req_rdy;
  logic [31:0] req_data = '0;
  logic        dc_rdy = 1'b0, dc_den, dc_hold, busy, err_timeout;
  logic [7:0]  dc_din;
  logic [2:0]  grant_id;

  compress_arbiter #(.NREQ(NREQ), .MAX_BURST(MAXB), .STALL_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_data(req_data), .req_last(req_last),
    .req_rdy(req_rdy), .dc_rdy(dc_rdy), .dc_din(dc_din), .dc_den(dc_den), .dc_hold(dc_hold),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  // reference model: owner -1 means nobody holds the compressor; stall -1 means not stalled
  int m_owner, m_rr, m_beats, m_stall, m_gid, m_din, m_den, m_err;
  int tcnt[NREQ];
  int grants[$], blen[$];
  int den_n, hold_n, err_n;
  logic prev_busy;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
  endfunction

  function automatic void m_reset();
    m_owner = -1; m_rr = 0; m_beats = 0; m_stall = -1;
    m_gid = 0; m_din = 0; m_den = 0; m_err = 0;
  endfunction

  function automatic int m_pick(logic [3:0] v);
`ifdef COMPRESS_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) if (v[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    return -1;
  endfunction

  function automatic void m_step(logic [3:0] v, logic [31:0] d, logic [3:0] l, logic r);
    m_den = 0; m_err = 0;
    if (m_owner < 0) begin
      if (r && v != 0) begin
        m_owner = m_pick(v); m_gid = m_owner; m_beats = 0; m_stall = -1;
      end
    end else if (v[m_owner] && r) begin
      m_din = (d >> (8 * m_owner)) & 32'hff; m_den = 1; m_beats++; m_stall = -1;
      if (l[m_owner] || m_beats == MAXB) begin
        m_rr = (m_owner + 1) % NREQ; m_owner = -1; m_beats = 0;
      end
    end else if (r) begin
      if (m_stall < 0) m_stall = 0;
      else begin
        m_stall++;
        if (m_stall == SMAX) begin
          m_err = 1; m_rr = (m_owner + 1) % NREQ; m_owner = -1; m_stall = -1; m_beats = 0;
        end
      end
    end
  endfunction

  task automatic clear_stats();
    grants.delete(); blen.delete();
    den_n = 0; hold_n = 0; err_n = 0;
    for (int i = 0; i < NREQ; i++) tcnt[i] = 0;
  endtask

  // One clock: drive at negedge, check the combinational ready, advance the model, compare at next negedge.
  task automatic cycle(input logic [3:0] v, input logic [3:0] l, input logic r);
    logic [3:0] exp_rdy;
    req_vld = v; req_last = l; dc_rdy = r; req_data = $urandom;
    #1;
    exp_rdy = (m_owner >= 0 && r) ? (4'b1 << m_owner) : 4'b0;
    chk("req_rdy", 32'(req_rdy), 32'(exp_rdy));
    for (int i = 0; i < NREQ; i++) if (v[i] && exp_rdy[i]) tcnt[i]++;
    m_step(v, req_data, l, r);
    @(negedge clk);
    chk("dc_din", 32'(dc_din), 32'(m_din));
    chk("dc_den", 32'(dc_den), 32'(m_den));
    chk("dc_hold", 32'(dc_hold), 32'(m_stall >= 0));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("err_timeout", 32'(err_timeout), 32'(m_err));
    if (dc_den && dc_hold) chk("den_and_hold", 32'(1), 32'(0));
    if (busy && !prev_busy) begin grants.push_back(int'(grant_id)); blen.push_back(0); end
    if (dc_den && blen.size() > 0) blen[blen.size()-1]++;
    den_n += int'(dc_den); hold_n += int'(dc_hold); err_n += int'(err_timeout);
    prev_busy = busy;
  endtask

  task automatic chk_zero_outs(string tag);
    chk({tag, "_req_rdy"}, 32'(req_rdy), 32'(0));
    chk({tag, "_dc_din"}, 32'(dc_din), 32'(0));
    chk({tag, "_dc_den"}, 32'(dc_den), 32'(0));
    chk({tag, "_dc_hold"}, 32'(dc_hold), 32'(0));
    chk({tag, "_grant_id"}, 32'(grant_id), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_err"}, 32'(err_timeout), 32'(0));
  endtask

  initial begin
    logic [3:0] v, l;
    m_reset(); clear_stats(); prev_busy = 1'b0;
    req_vld = 4'b1111; dc_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero_outs("reset");
    rst_n = 1'b1;

    // Two requesters alternating with 2-beat bursts.
    clear_stats();
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NREQ; i++) l[i] = tcnt[i][0];
      cycle(4'b0101, l, 1'b1);
    end
    repeat (3) cycle(4'b0000, 4'b0000, 1'b1);
    chk("alt_ngrants", 32'(grants.size()), 32'(4));
    chk("alt_dens", 32'(den_n), 32'(8));
    for (int g = 0; g < grants.size() && g < 4; g++) begin
`ifdef COMPRESS_ARB_PRIO_EN
      chk("alt_grant", 32'(grants[g]), 32'(0));
`else
      chk("alt_grant", 32'(grants[g]), 32'((g % 2) * 2));
`endif
      chk("alt_blen", 32'(blen[g]), 32'(2));
    end

    // Long stream from requester 1 chopped at the burst limit.
    clear_stats();
    for (int c = 0; c < 60 && tcnt[1] < 20; c++) cycle(4'b0010, (tcnt[1] == 19) ? 4'b0010 : 4'b0000, 1'b1);
    repeat (3) cycle(4'b0000, 4'b0000, 1'b1);
    chk("long_ngrants", 32'(grants.size()), 32'(3));
    if (grants.size() == 3) begin
      chk("long_b0", 32'(blen[0]), 32'(8));
      chk("long_b1", 32'(blen[1]), 32'(8));
      chk("long_b2", 32'(blen[2]), 32'(4));
      chk("long_owner", 32'(grants[2]), 32'(1));
    end

    // Short gap: three missing beats give exactly three hold cycles.
    clear_stats();
    for (int c = 0; c < 8; c++) begin
      v = ((c < 3 || c >= 6) && tcnt[3] < 4) ? 4'b1000 : 4'b0000;
      cycle(v, (tcnt[3] == 3) ? 4'b1000 : 4'b0000, 1'b1);
    end
    repeat (3) cycle(4'b0000, 4'b0000, 1'b1);
    chk("gap_hold", 32'(hold_n), 32'(3));
    chk("gap_den", 32'(den_n), 32'(4));
    chk("gap_err", 32'(err_n), 32'(0));

    // Long gap: owner 2 vanishes, stall aborts, pending requester 0 takes over.
    clear_stats();
    for (int c = 0; c < 26; c++) begin
      v = '0;
      if (c < 3) v[2] = 1'b1;
      if (c >= 1 && tcnt[0] == 0) v[0] = 1'b1;
      cycle(v, 4'b0001, 1'b1);
    end
    chk("abort_err", 32'(err_n), 32'(1));
    chk("abort_hold", 32'(hold_n), 32'(SMAX));
    chk("abort_ngrants", 32'(grants.size()), 32'(2));
    if (grants.size() == 2) begin
      chk("abort_g0", 32'(grants[0]), 32'(2));
      chk("abort_g1", 32'(grants[1]), 32'(0));
    end

    // Compressor back-pressure during a burst: no hold, burst resumes.
    clear_stats();
    for (int c = 0; c < 10; c++)
      cycle((tcnt[1] < 4) ? 4'b0010 : 4'b0000, (tcnt[1] == 3) ? 4'b0010 : 4'b0000, !(c >= 2 && c < 7));
    repeat (3) cycle(4'b0000, 4'b0000, 1'b1);
    chk("bp_hold", 32'(hold_n), 32'(0));
    chk("bp_den", 32'(den_n), 32'(4));
    chk("bp_ngrants", 32'(grants.size()), 32'(1));
    if (blen.size() == 1) chk("bp_blen", 32'(blen[0]), 32'(4));

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      v = 4'($urandom);
      for (int i = 0; i < NREQ; i++) l[i] = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 49) == 0) repeat ($urandom_range(10, 20)) cycle(4'b0000, 4'b0000, 1'b1);
      cycle(v, l, $urandom_range(0, 9) != 0);
    end

    // Reset in the middle of a burst, then restart from requester 0.
    for (int c = 0; c < 10 && !busy; c++) cycle(4'b1111, 4'b0000, 1'b1);
    cycle(4'b1111, 4'b0000, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_zero_outs("midrst");
    m_reset(); clear_stats(); prev_busy = 1'b0;
    @(negedge clk);
    chk_zero_outs("inrst");
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < NREQ; i++) l[i] = tcnt[i][0];
      cycle(4'b1111, l, 1'b1);
    end
    chk("rst_ngrants", 32'(grants.size() >= 6), 32'(1));
    for (int g = 0; g < grants.size(); g++) begin
`ifdef COMPRESS_ARB_PRIO_EN
      chk("rst_grant", 32'(grants[g]), 32'(0));
`else
      chk("rst_grant", 32'(grants[g]), 32'(g % NREQ));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
